inst_queue: RTL and testbench
=============================

# inst_queue

Decoupling buffer between the fetch stage and decode. Captures fetched instruction packets (instruction word, PC, fault cause and tval) in a small FIFO, presents them to decode with a valid/ready handshake, and stops accepting fetch output after a faulting packet. Branch, jump and trap redirects empty it in one cycle. Lets fetch keep running while decode stalls, and feeds decode a bubble-free stream once refilled.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  redirect (clear | bj_en | trap_en); discard all entries
- in_valid  input  1  fetch packet present
- in_ready  output  1  queue accepts a packet this cycle
- in_inst  input  32  instruction word
- in_pc  input  64  instruction PC
- in_cause  input  5  fault cause; 0 = no fault
- in_tval  input  64  fault value
- out_valid  output  1  head packet valid for decode
- out_ready  input  1  decode consumes head (= !stall)
- out_inst  output  32  head instruction; 32'h0000_0013 (NOP) when !out_valid
- out_pc  output  64  head PC; 0 when !out_valid
- out_cause  output  5  head cause; 0 when !out_valid
- out_tval  output  64  head tval; 0 when !out_valid
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH-entry circular buffer. Read and write pointers are $clog2(DEPTH)+1 bits; the MSB disambiguates full from empty. Pointers wrap modulo 2·DEPTH.
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both may occur in the same cycle; count is then unchanged.
- in_ready = !full && !fault_hold && !flush.
- fault_hold: set when a packet with in_cause != 0 is pushed. While set, no packets are accepted, so nothing younger than a fault enters decode. Cleared only by flush or reset.
- Flush: pointers, count and fault_hold go to 0 on the next edge. Flush overrides any push or pop in the same cycle. out_valid is forced to 0 combinationally during the flush cycle.
- A pop of the final entry with no push leaves the queue empty next cycle; out_* then return to their idle values.
- Reset (asynchronous, mid-operation included): pointers = 0, count = 0, fault_hold = 0. All outputs take their idle values immediately: out_valid=0, out_inst=NOP, other out_*=0, in_ready=1.

## Timing
- Base latency: a packet pushed at edge N is visible on out_* in the cycle after N, provided the queue was empty.
- Throughput: one packet per cycle in and out in steady state.
- Full: a push is refused, because in_ready=0. A pop that cycle frees the entry, and in_ready=1 again the following cycle. There is no same-cycle pass-through when full.
- in_ready depends on registered state plus flush only. It never depends on out_ready.
- out_* come from storage and registered pointers. There is no combinational path from in_* to out_*, except under the bypass option below.

## Configuration
- INST_QUEUE_BYPASS_EN defined: when the queue is empty and !flush, out_* = in_* and out_valid = in_valid combinationally.
  - If out_ready is also 1, the packet is consumed directly and not written.
  - A bypassed faulting packet still sets fault_hold.
  - Latency is 0 cycles when empty.
- Not defined: no bypass; latency is always ≥1 cycle.

## Structure
- Shared package (isa package): the packet struct {inst[31:0], pc[63:0], cause[4:0], tval[63:0]} and the NOP encoding constant 32'h0000_0013.
- One sub-module, inst_queue_mem: DEPTH × packet register array with one write port and one asynchronous read port. Pointer, count and fault_hold logic live in inst_queue.

## Test plan
- Reset release, push pc=0x8000_0000 inst=0x0000_0513 with out_ready=1 -> out_valid=1 next cycle with the same pc and inst; count 1 -> 0 after the pop.
- Hold out_ready=0 and push 5 packets (pc 0x0, 0x4, …) -> in_ready=0 after 4 accepted; count=4. Release out_ready -> packets pop in order 0x0, 0x4, 0x8, 0xC; the 5th (0x10) is accepted the cycle after the first pop.
- Simultaneous push+pop for 16 cycles with DEPTH=4 -> count stays constant, PCs are contiguous, and pointers wrap twice without loss.
- Push a packet with in_cause=12, tval=0x1000 followed by in_valid=1 continuing -> in_ready=0 from the next cycle. Decode sees the fault packet and no packet after it. flush -> in_ready=1 and count=0.
- With 3 entries queued, assert flush together with push and pop -> next cycle count=0 and out_valid=0; the pushed packet is discarded.
- Assert rst_n=0 asynchronously between edges with the queue full -> all outputs are at their idle values immediately, before the next clock edge.
- With INST_QUEUE_BYPASS_EN, empty queue, in_valid=1 and out_ready=1 -> out_valid=1 in the same cycle, and count stays 0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: the fetched packet
// layout and the NOP encoding decode sees when the queue has nothing to offer.
package inst_queue_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [4:0]  cause;
        logic [63:0] tval;
    } pkt_t;

    localparam int PKT_W = $bits(pkt_t);

    // Packet presented to decode whenever no valid head exists.
    function automatic pkt_t idle_pkt();
        pkt_t p;
        p.inst  = NOP_INST;
        p.pc    = 64'd0;
        p.cause = 5'd0;
        p.tval  = 64'd0;
        return p;
    endfunction

    // A non-zero cause marks a faulting fetch.
    function automatic logic is_fault(input logic [4:0] cause);
        return (cause != 5'd0);
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for inst_queue. The queue uses the slave
// modport; the fetch/decode environment uses the master modport.
interface inst_queue_if #(
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_inst;
    logic [63:0]              in_pc;
    logic [4:0]               in_cause;
    logic [63:0]              in_tval;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_inst;
    logic [63:0]              out_pc;
    logic [4:0]               out_cause;
    logic [63:0]              out_tval;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_cause, in_tval, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_cause, out_tval, count
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, in_cause, in_tval, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_cause, out_tval, count
    );

endinterface

// File: rtl/inst_queue_mem.sv
// Packet storage for inst_queue: DEPTH entries, one synchronous write port and
// one asynchronous read port. Contents need no reset; validity is tracked by
// the pointers in the parent.
module inst_queue_mem
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  pkt_t                       i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output pkt_t                       o_rdata
);

    pkt_t r_mem [DEPTH];

    // Write the incoming packet into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer with MSB-extended pointers, a fault hold that blocks
// everything younger than a faulting fetch, and a one-cycle flush for redirects.
// Optional macro INST_QUEUE_BYPASS_EN: when the queue is empty the incoming
// packet is shown to decode in the same cycle and, if taken, never stored.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    inst_queue_if.slave  q
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_count;
    logic          r_fault_hold;

    logic          w_empty;
    logic          w_full;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_direct;
    logic          w_wr;
    logic          w_rd;
    pkt_t          w_in_pkt;
    pkt_t          w_head_pkt;
    pkt_t          w_out_pkt;

    // Gather the incoming fetch fields into one packet.
    always_comb begin
        w_in_pkt.inst  = q.in_inst;
        w_in_pkt.pc    = q.in_pc;
        w_in_pkt.cause = q.in_cause;
        w_in_pkt.tval  = q.in_tval;
    end

    // Equal pointers mean empty; equal index with differing wrap bit means full.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

    // Acceptance depends only on registered state and the redirect.
    assign w_in_ready = !w_full && !r_fault_hold && !q.flush;

    // Choose what decode sees: stored head, bypassed input, or the idle packet.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_pkt   = idle_pkt();
        if (q.flush) begin
            w_out_valid = 1'b0;
            w_out_pkt   = idle_pkt();
        end else if (!w_empty) begin
            w_out_valid = 1'b1;
            w_out_pkt   = w_head_pkt;
`ifdef INST_QUEUE_BYPASS_EN
        end else if (q.in_valid && !r_fault_hold) begin
            w_out_valid = 1'b1;
            w_out_pkt   = w_in_pkt;
`endif
        end else begin
            w_out_valid = 1'b0;
            w_out_pkt   = idle_pkt();
        end
    end

    assign w_push   = q.in_valid && w_in_ready;
    assign w_pop    = w_out_valid && q.out_ready;
    // A pop while empty can only be a bypassed packet taken straight by decode.
    assign w_direct = w_pop && w_empty;
    assign w_wr     = w_push && !w_direct;
    assign w_rd     = w_pop && !w_empty;

    inst_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (w_in_pkt),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_head_pkt)
    );

    // Advance pointers and occupancy; a redirect discards everything and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= PTR_ZERO;
        end else if (q.flush) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= PTR_ZERO;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Once a faulting packet is accepted, refuse fetch output until redirected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_hold <= 1'b0;
        end else if (q.flush) begin
            r_fault_hold <= 1'b0;
        end else if (w_push && is_fault(q.in_cause)) begin
            r_fault_hold <= 1'b1;
        end
    end

    assign q.in_ready  = w_in_ready;
    assign q.out_valid = w_out_valid;
    assign q.out_inst  = w_out_pkt.inst;
    assign q.out_pc    = w_out_pkt.pc;
    assign q.out_cause = w_out_pkt.cause;
    assign q.out_tval  = w_out_pkt.tval;
    assign q.count     = r_count;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized
// traffic, all compared against a packet-queue reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 2 + CW + PKT_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    inst_queue_if #(.DEPTH(DEPTH)) q ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: packets held, and whether a fault blocks fetch.
    pkt_t          mq[$];
    bit            m_hold;
    logic          e_valid;
    logic          e_ready;
    logic [CW-1:0] e_count;
    pkt_t          e_pkt;
    logic [63:0]   next_pc;

    wire [VW-1:0] obs = {q.out_valid, q.in_ready, q.count,
                         q.out_inst, q.out_pc, q.out_cause, q.out_tval};
    wire [VW-1:0] idle_vec = {1'b0, 1'b1, {CW{1'b0}}, 32'h0000_0013, 64'd0, 5'd0, 64'd0};

    function automatic bit bypass_on();
`ifdef INST_QUEUE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic pkt_t mk(input logic [63:0] pc, input logic [31:0] inst,
                                input logic [4:0] cause, input logic [63:0] tval);
        pkt_t p;
        p.inst = inst; p.pc = pc; p.cause = cause; p.tval = tval;
        return p;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_valid, e_ready, e_count, e_pkt};
    endfunction

    task automatic model_eval();
        pkt_t inp;
        inp = mk(q.in_pc, q.in_inst, q.in_cause, q.in_tval);
        e_ready = (mq.size() < DEPTH) && !m_hold && !q.flush;
        e_count = CW'(mq.size());
        e_valid = 1'b0;
        e_pkt   = mk(64'd0, 32'h0000_0013, 5'd0, 64'd0);
        if (!q.flush) begin
            if (mq.size() > 0) begin
                e_valid = 1'b1; e_pkt = mq[0];
            end else if (bypass_on() && q.in_valid && !m_hold) begin
                e_valid = 1'b1; e_pkt = inp;
            end
        end
    endtask

    task automatic model_commit();
        pkt_t inp;
        bit push, pop, direct;
        model_eval();
        inp = mk(q.in_pc, q.in_inst, q.in_cause, q.in_tval);
        if (q.flush) begin
            mq.delete();
            m_hold = 1'b0;
        end else begin
            push   = q.in_valid && e_ready;
            pop    = e_valid && q.out_ready;
            direct = pop && (mq.size() == 0);
            if (pop && !direct) void'(mq.pop_front());
            if (push && !direct) mq.push_back(inp);
            if (push && q.in_cause != 5'd0) m_hold = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
        model_eval();
    endtask

    task automatic drive(input bit v, input pkt_t p, input bit rdy, input bit fl);
        q.in_valid = v; q.in_inst = p.inst; q.in_pc = p.pc;
        q.in_cause = p.cause; q.in_tval = p.tval;
        q.out_ready = rdy; q.flush = fl;
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b0, 1'b0);
        checks++;
        if (obs !== idle_vec) begin
            errors++; $display("FAIL reset_idle got %h want %h", obs, idle_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive(1'b1, mk(64'h8000_0000, 32'h0000_0513, 5'd0, 64'd0), 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL basic c%0d got %h want %h", c, obs, exp_vec());
            end
            tick();
            drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b1, 1'b0);
        end
    endtask

    task automatic test_fill();
        int k = 0;
        int first_pop = -1;
        int acc5 = -1;
        logic [63:0] got[$];
        bit acc;
        for (int c = 0; c < 6; c++) begin
            drive(k < 5, mk(64'(k * 4), $urandom, 5'd0, 64'd0), 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL fill c%0d got %h want %h", c, obs, exp_vec());
            end
            acc = q.in_valid && q.in_ready;
            tick();
            if (acc) k++;
        end
        drive(1'b1, mk(64'h10, $urandom, 5'd0, 64'd0), 1'b0, 1'b0);
        checks++;
        if (q.count !== CW'(4) || q.in_ready !== 1'b0 || k !== 4) begin
            errors++; $display("FAIL fill_full count %0d in_ready %0b accepted %0d want 4 0 4", q.count, q.in_ready, k);
        end
        for (int c = 0; c < 10; c++) begin
            drive(k < 5, mk(64'(k * 4), $urandom, 5'd0, 64'd0), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL drain c%0d got %h want %h", c, obs, exp_vec());
            end
            if (q.out_valid && q.out_ready) begin
                got.push_back(q.out_pc);
                if (first_pop < 0) first_pop = c;
            end
            acc = q.in_valid && q.in_ready;
            tick();
            if (acc) begin
                if (k == 4) acc5 = c;
                k++;
            end
        end
        checks++;
        if (got.size() < 5 || got[0] !== 64'h0 || got[1] !== 64'h4 || got[2] !== 64'h8
            || got[3] !== 64'hC || got[4] !== 64'h10) begin
            errors++; $display("FAIL fill_order pops %0d first %h want 0,4,8,c,10", got.size(), (got.size() > 0) ? got[0] : 64'hx);
        end
        checks++;
        if (first_pop !== 0 || acc5 !== 1) begin
            errors++; $display("FAIL fill_refill first_pop %0d fifth_accept %0d want 0 1", first_pop, acc5);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, mk(64'h2000 + 64'(c * 4), $urandom, 5'd0, 64'd0), 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, mk(64'h2008 + 64'(c * 4), $urandom, 5'd0, 64'd0), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec() || q.count !== CW'(2) || q.out_pc !== 64'h2000 + 64'(c * 4)) begin
                errors++; $display("FAIL b2b c%0d got %h want %h", c, obs, exp_vec());
            end
            tick();
        end
        drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_fault();
        drive(1'b1, mk(64'h3000, 32'h0000_0073, 5'd12, 64'h1000), 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL fault_push got %h want %h", obs, exp_vec());
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, mk(64'h3004 + 64'(c * 4), $urandom, 5'd0, 64'd0), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec() || q.in_ready !== 1'b0) begin
                errors++; $display("FAIL fault_hold c%0d got %h want %h", c, obs, exp_vec());
            end
            tick();
        end
        drive(1'b1, mk(64'h4000, $urandom, 5'd0, 64'd0), 1'b1, 1'b1);
        tick();
        drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b0, 1'b0);
        checks++;
        if (q.in_ready !== 1'b1 || q.count !== CW'(0)) begin
            errors++; $display("FAIL fault_flush in_ready %0b count %0d want 1 0", q.in_ready, q.count);
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, mk(64'h5000 + 64'(c * 4), $urandom, 5'd0, 64'd0), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, mk(64'h500C, $urandom, 5'd0, 64'd0), 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || q.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got %h want %h", obs, exp_vec());
        end
        tick();
        drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b0, 1'b0);
        checks++;
        if (q.count !== CW'(0) || q.out_valid !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL flush_after count %0d out_valid %0b want 0 0", q.count, q.out_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, mk(64'h6000 + 64'(c * 4), $urandom, 5'd0, 64'd0), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b0, 1'b0);
        checks++;
        if (q.count !== CW'(4) || q.out_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre count %0d want 4", q.count);
        end
        rst_n = 1'b0;
        mq.delete();
        m_hold = 1'b0;
        #1;
        checks++;
        if (obs !== idle_vec) begin
            errors++; $display("FAIL areset_idle got %h want %h", obs, idle_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
`ifdef INST_QUEUE_BYPASS_EN
        drive(1'b1, mk(64'h7000, 32'h0000_0593, 5'd0, 64'd0), 1'b1, 1'b0);
        checks++;
        if (q.out_valid !== 1'b1 || q.out_pc !== 64'h7000 || q.count !== CW'(0)) begin
            errors++; $display("FAIL bypass_same got v%0b pc %h cnt %0d want 1 7000 0", q.out_valid, q.out_pc, q.count);
        end
        tick();
        drive(1'b0, mk(64'd0, 32'd0, 5'd0, 64'd0), 1'b0, 1'b0);
        checks++;
        if (q.count !== CW'(0)) begin
            errors++; $display("FAIL bypass_count got %0d want 0", q.count);
        end
`endif
    endtask

    task automatic test_random();
        bit v, rdy, fl, acc;
        logic [4:0] cause;
        next_pc = 64'h9000;
        for (int c = 0; c < 400; c++) begin
            v     = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            fl    = ($urandom_range(0, 19) == 0);
            cause = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            drive(v, mk(next_pc, $urandom, cause, {$urandom, $urandom}), rdy, fl);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random c%0d got %h want %h", c, obs, exp_vec());
            end
            acc = q.in_valid && q.in_ready;
            tick();
            if (acc) next_pc = next_pc + 64'd4;
        end
    endtask

    initial begin
        m_hold = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_fault();
        test_flush();
        test_async_reset();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
